// File: rtl/uart_rx_frame_checker.sv
// UART receive frame checker: resynchronises the frame-done level and checks
// the start, stop and parity bits of each frame. Checked bytes are queued in a
// small FIFO, the head entry is presented on a valid/ready port, and saturating
// parity/framing error statistics are kept.
module uart_rx_frame_checker #(
  parameter int DEPTH      = 4,
  parameter int PARITY_ODD = 0,
  parameter int CNT_W      = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [10:0]              rx_frame,
  input  logic                     rx_valid,
  input  logic                     rx_ferror,
  output logic [7:0]               out_data,
  output logic                     out_perr,
  output logic                     out_ferr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     overflow,
  output logic [CNT_W-1:0]         perr_count,
  output logic [CNT_W-1:0]         ferr_count,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL  = LW'(DEPTH);
  localparam logic          PAR_SENSE = 1'(PARITY_ODD);

  // Parity over data plus parity bit must match the configured sense.
  function automatic logic parity_err(input logic [10:0] frame);
    return (^frame[9:1]) != PAR_SENSE;
  endfunction

  // Framing is bad if the receiver flagged it, start is high or stop is low.
  function automatic logic framing_err(input logic [10:0] frame, input logic fe);
    return fe | frame[0] | ~frame[10];
  endfunction

  // Counter increment that sticks at all-ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic          s1, s2, s3;
  logic          new_frame;
  logic          perr_in, ferr_in;
  logic [9:0]    entry_in;
  logic [9:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          full, do_read, do_write;
  logic [9:0]    head;

  assign new_frame = s2 & ~s3;
  assign perr_in   = parity_err(rx_frame);
  assign ferr_in   = framing_err(rx_frame, rx_ferror);
  assign entry_in  = {ferr_in, perr_in, rx_frame[8:1]};

  assign full      = (fifo_level == FULL_LVL);
  assign out_valid = (fifo_level != '0);
  assign do_read   = out_valid & out_ready;
  // A read in the same cycle frees a slot, so a full FIFO still accepts the write.
  assign do_write  = new_frame & (~full | do_read);

  assign head      = mem[rd_ptr];
  assign out_data  = out_valid ? head[7:0] : 8'h00;
  assign out_perr  = out_valid & head[8];
  assign out_ferr  = out_valid & head[9];

  // Two-flop synchroniser for the asynchronous frame-done level plus edge-detect delay.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= rx_valid;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // Entry storage; contents are only visible through a valid head pointer.
  always_ff @(posedge clk) begin
    if (do_write) begin
      mem[wr_ptr] <= entry_in;
    end
  end

  // FIFO pointers, occupancy, sticky overflow and saturating error counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      overflow   <= 1'b0;
      perr_count <= '0;
      ferr_count <= '0;
    end else begin
      if (do_write) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_read) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_write, do_read})
        2'b10:   fifo_level <= fifo_level + LW'(1);
        2'b01:   fifo_level <= fifo_level - LW'(1);
        default: fifo_level <= fifo_level;
      endcase
      if (new_frame & full & ~do_read) begin
        overflow <= 1'b1;
      end
      // Statistics count every strobed frame, including dropped ones.
      if (new_frame & perr_in) begin
        perr_count <= sat_inc(perr_count);
      end
      if (new_frame & ferr_in) begin
        ferr_count <= sat_inc(ferr_count);
      end
    end
  end

endmodule

// File: doc/uart_rx_frame_checker.md
Name: uart_rx_frame_checker

Overview:
- Downstream stage of the UART reception block; consumes each completed 11-bit received frame plus its framing-error flag.
- Resynchronises the frame-done indication into the system clock domain and checks start, stop and parity bits.
- Extracts the data byte and queues byte plus error status in a small FIFO.
- Presents queued entries to the LED/display consumer over a valid/ready handshake, and keeps saturating error statistics.

Parameters:
- DEPTH, 4, FIFO entries; power of two, 2..16.
- PARITY_ODD, 0, 0 = even parity expected over data+parity bits; 1 = odd.
- CNT_W, 8, width of each error counter.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- rx_frame  in  11  received frame: [0] start, [8:1] data (LSB first, bit1 = D0), [9] parity, [10] stop
- rx_valid  in  1  frame-done level from the receiver; asynchronous to clk; a new frame is signalled by a 0->1 transition
- rx_ferror  in  1  framing error reported by the receiver for the same frame
- out_data  out  8  head-of-FIFO data byte
- out_perr  out  1  head entry parity error
- out_ferr  out  1  head entry framing error: rx_ferror, OR start bit = 1, OR stop bit = 0
- out_valid  out  1  FIFO not empty
- out_ready  in  1  consumer accepts the head entry when out_valid && out_ready
- overflow  out  1  sticky; a frame arrived while the FIFO was full
- perr_count  out  CNT_W  saturating count of parity-error frames
- ferr_count  out  CNT_W  saturating count of framing-error frames
- fifo_level  out  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Reset: all of the following are 0 while reset is high and on the first cycle after it: FIFO pointers, fifo_level, out_valid, out_data, out_perr, out_ferr, overflow, both counters, and the synchroniser and edge-detect flops.
- Synchroniser: rx_valid passes through 2 flops (s1, s2), then a delay flop s3. Strobe new_frame = s2 & ~s3, a 1-cycle pulse.
- rx_frame and rx_ferror are sampled on the new_frame cycle. They are quasi-static (stable for a full bit time after rx_valid rises), so they need no separate synchroniser.
- Latency: rx_valid rising at clk edge N (setup met) gives new_frame in cycle N+2. The entry is written at the end of that cycle. out_valid is high from cycle N+3.
- Parity check: p = ^rx_frame[9:1]. Parity error when p != PARITY_ODD.
- Framing check: ferr = rx_ferror | rx_frame[0] | ~rx_frame[10].
- FIFO entry is {ferr, perr, data}. out_* show the head entry combinationally from storage. out_data/perr/ferr = 0 when empty.
- Write: on new_frame when level < DEPTH.
- Read: on out_valid && out_ready.
- Simultaneous write and read:
  - FIFO non-empty: both occur, level unchanged.
  - FIFO empty: only the write occurs (out_valid was 0).
  - FIFO full: the read frees a slot, so the write is also accepted and overflow is not set.
- Overflow: new_frame while full with no read in the same cycle drops the frame and sets overflow to 1. overflow stays 1 until reset.
- Pointers wrap modulo DEPTH.
- Counters:
  - perr_count increments on every new_frame whose parity fails; ferr_count on every new_frame whose framing check fails. This applies even when the frame is dropped.
  - A frame failing both checks increments both counters.
  - Each counter saturates at 2^CNT_W-1.
- rx_valid stuck high produces no further strobes. The next frame requires a 0 then a 1.
- Reset asserted mid-operation: FIFO contents are discarded and the edge detector is cleared. If rx_valid is already high when reset deasserts, s2 reaches 1 while s3 follows one cycle later. That produces at most one spurious strobe, which is acceptable and is counted normally.

Test Plan:
- Reset, then a valid frame 11'b1_0_10100101_0 (data 0xA5, even parity bit 0), rx_valid 0->1 -> out_valid high 3 cycles later; out_data=0xA5, perr=0, ferr=0, fifo_level=1; ready=1 -> empty next cycle.
- Frame with data 0x01 and parity bit 0 (even mode) -> out_perr=1, perr_count=1, ferr_count=0. Repeat with PARITY_ODD=1 -> perr=0.
- Stop bit 0 (frame 11'b0_1_00000001_0), then a clean frame with rx_ferror=1 -> both entries ferr=1, ferr_count=2.
- out_ready held 0, 5 frames 0x10..0x14 with DEPTH=4 -> level=4, overflow=1 after the 5th; drain yields 0x10,0x11,0x12,0x13 in order.
- FIFO full and out_ready=1 in the same cycle as new_frame -> level stays 4, overflow stays 0, order preserved.
- CNT_W=2, 5 parity-bad frames -> perr_count saturates at 3. Reset asserted mid-stream -> all outputs 0 next cycle.
